// File: rtl/codec_config_sequencer_if.sv
// Handshake bundle between the codec config sequencer, its register table and the I2C write engine.
interface codec_config_sequencer_if #(
    parameter int IDX_W = 4
);
    logic             go;
    logic             busy;
    logic             cfg_done;
    logic             cfg_error;
    logic [IDX_W-1:0] err_index;
    logic [IDX_W-1:0] cfg_index;
    logic [15:0]      cfg_word;
    logic             i2c_start;
    logic [23:0]      i2c_data;
    logic             i2c_done;
    logic             i2c_ack;

    modport master (
        input  go, cfg_word, i2c_done, i2c_ack,
        output busy, cfg_done, cfg_error, err_index, cfg_index, i2c_start, i2c_data
    );

    modport slave (
        output go, cfg_word, i2c_done, i2c_ack,
        input  busy, cfg_done, cfg_error, err_index, cfg_index, i2c_start, i2c_data
    );
endinterface

// File: rtl/codec_config_sequencer.sv
// Walks the codec register table, issuing one {DEV_ADDR, word} I2C write per entry.
// Define CODEC_CFG_RETRY_EN to retry NACKed entries up to MAX_RETRIES times.
module codec_config_sequencer #(
    parameter int         NUM_REGS      = 11,
    parameter int         IDX_W         = 4,
    parameter logic [7:0] DEV_ADDR      = 8'h34,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         MAX_RETRIES   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    codec_config_sequencer_if.master bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, SETTLE, LOAD, START, GUARD, WAIT, CHECK, FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] eidx_q, eidx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic [23:0]      data_q, data_d;
    logic             retry_left;

`ifdef CODEC_CFG_RETRY_EN
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RTY_W-1:0] retry_q, retry_d;
    assign retry_left = (int'(retry_q) < MAX_RETRIES);
`else
    assign retry_left = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        eidx_d  = eidx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        start_d = 1'b0;
        data_d  = data_q;
`ifdef CODEC_CFG_RETRY_EN
        retry_d = retry_q;
`endif
        unique case (state_q)
            IDLE, FINISH: begin
                if (bus.go) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    eidx_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                data_d  = {DEV_ADDR, bus.cfg_word};
                start_d = 1'b1;
                state_d = START;
            end
            START: state_d = GUARD;
            // The engine's done from the previous frame is still high here.
            GUARD: state_d = WAIT;
            WAIT: begin
                if (bus.i2c_done) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (!bus.i2c_ack && retry_left) begin
`ifdef CODEC_CFG_RETRY_EN
                    retry_d = retry_q + 1'b1;
`endif
                    state_d = SETTLE;
                end else begin
                    if (!bus.i2c_ack && !err_q) begin
                        err_d  = 1'b1;
                        eidx_d = idx_q;
                    end
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
`ifdef CODEC_CFG_RETRY_EN
                        retry_d = '0;
`endif
                        state_d = SETTLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            eidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
`ifdef CODEC_CFG_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            eidx_q  <= eidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            data_q  <= data_d;
`ifdef CODEC_CFG_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.cfg_done  = done_q;
    assign bus.cfg_error = err_q;
    assign bus.err_index = eidx_q;
    assign bus.cfg_index = idx_q;
    assign bus.i2c_start = start_q;
    assign bus.i2c_data  = data_q;
endmodule
